// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: valid/ready handshake, 2-entry skid buffer, flush with NOP injection.
// Optional saturating perf counters (stall_cycles, flush_count) when IFID_PERF_CNT_EN is defined.
module if_id_stage_reg #(
   parameter int unsigned PC_WIDTH    = 12,
   parameter int unsigned INSTR_WIDTH = 32,
   parameter logic [31:0] NOP_INSTR   = 32'h00000013,
   parameter int unsigned CNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   if_valid,
   output logic                   if_ready,
   input  logic [PC_WIDTH-1:0]    if_pc,
   input  logic [INSTR_WIDTH-1:0] if_instruction,
   input  logic                   flush,
   output logic                   id_valid,
   input  logic                   id_ready,
   output logic [PC_WIDTH-1:0]    id_pc,
   output logic [INSTR_WIDTH-1:0] id_instruction
`ifdef IFID_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]   stall_cycles,
   output logic [CNT_WIDTH-1:0]   flush_count
`endif
);

   localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_INSTR);

   if (CNT_WIDTH < 1 || PC_WIDTH < 1 || INSTR_WIDTH < 1) begin : g_bad_param
      $error("if_id_stage_reg: widths must be >= 1");
   end

   logic                   main_valid_q, main_valid_d;
   logic [PC_WIDTH-1:0]    main_pc_q,    main_pc_d;
   logic [INSTR_WIDTH-1:0] main_instr_q, main_instr_d;
   logic                   skid_valid_q, skid_valid_d;
   logic [PC_WIDTH-1:0]    skid_pc_q,    skid_pc_d;
   logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;

   logic acc;
   logic drn;

   assign if_ready       = ~skid_valid_q;
   assign id_valid       = main_valid_q;
   assign id_pc          = main_pc_q;
   assign id_instruction = main_instr_q;

   assign acc = if_valid & ~skid_valid_q;
   assign drn = main_valid_q & id_ready;

   always_comb begin
      main_valid_d = main_valid_q;
      main_pc_d    = main_pc_q;
      main_instr_d = main_instr_q;
      skid_valid_d = skid_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      // Flush squashes both slots; PCs are left as they were.
      if (flush) begin
         main_valid_d = 1'b0;
         main_instr_d = NOP;
         skid_valid_d = 1'b0;
         skid_instr_d = NOP;
      end else if (skid_valid_q) begin
         if (drn) begin
            main_valid_d = 1'b1;
            main_pc_d    = skid_pc_q;
            main_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
         end
      end else if (acc) begin
         if (!main_valid_q || drn) begin
            main_valid_d = 1'b1;
            main_pc_d    = if_pc;
            main_instr_d = if_instruction;
         end else begin
            skid_valid_d = 1'b1;
            skid_pc_d    = if_pc;
            skid_instr_d = if_instruction;
         end
      end else if (drn) begin
         main_valid_d = 1'b0;
         main_instr_d = NOP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         main_pc_q    <= '0;
         main_instr_q <= NOP;
         skid_valid_q <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP;
      end else begin
         main_valid_q <= main_valid_d;
         main_pc_q    <= main_pc_d;
         main_instr_q <= main_instr_d;
         skid_valid_q <= skid_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

`ifdef IFID_PERF_CNT_EN
   logic [CNT_WIDTH-1:0] stall_q, stall_d;
   logic [CNT_WIDTH-1:0] flcnt_q, flcnt_d;

   assign stall_cycles = stall_q;
   assign flush_count  = flcnt_q;

   // Both counters stick at all-ones instead of wrapping.
   always_comb begin
      stall_d = stall_q;
      flcnt_d = flcnt_q;
      if (main_valid_q && !id_ready && !flush && stall_q != '1) begin
         stall_d = stall_q + CNT_WIDTH'(1);
      end
      if (flush && (main_valid_q || skid_valid_q) && flcnt_q != '1) begin
         flcnt_d = flcnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         flcnt_q <= '0;
      end else begin
         stall_q <= stall_d;
         flcnt_q <= flcnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Self-checking bench for if_id_stage_reg: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_if_id_stage_reg;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_valid, if_ready, flush, id_valid, id_ready;
   logic [11:0] if_pc, id_pc;
   logic [31:0] if_instruction, id_instruction;

   logic        w_iv, w_irdy, w_idv, w_idr;
   logic [31:0] w_ipc, w_opc;
   logic [15:0] w_iins, w_oins;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

`ifdef IFID_PERF_CNT_EN
   logic [15:0] stall_cycles, flush_count;
   logic        s_irdy, s_idv;
   logic [11:0] s_opc;
   logic [31:0] s_oins;
   logic [1:0]  s_stall, s_flush;
`endif

   if_id_stage_reg u_dut (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_instruction(if_instruction),
      .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_pc(id_pc), .id_instruction(id_instruction)
`ifdef IFID_PERF_CNT_EN
      , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
   );

   if_id_stage_reg #(.PC_WIDTH(32), .INSTR_WIDTH(16)) u_wide (
      .clk(clk), .rst(rst),
      .if_valid(w_iv), .if_ready(w_irdy),
      .if_pc(w_ipc), .if_instruction(w_iins),
      .flush(1'b0),
      .id_valid(w_idv), .id_ready(w_idr),
      .id_pc(w_opc), .id_instruction(w_oins)
`ifdef IFID_PERF_CNT_EN
      , .stall_cycles(), .flush_count()
`endif
   );

`ifdef IFID_PERF_CNT_EN
   if_id_stage_reg #(.CNT_WIDTH(2)) u_sat (
      .clk(clk), .rst(rst),
      .if_valid(if_valid), .if_ready(s_irdy),
      .if_pc(if_pc), .if_instruction(if_instruction),
      .flush(flush),
      .id_valid(s_idv), .id_ready(id_ready),
      .id_pc(s_opc), .id_instruction(s_oins),
      .stall_cycles(s_stall), .flush_count(s_flush)
   );
`endif

   typedef struct {
      logic [11:0] pc;
      logic [31:0] ins;
   } ent_t;

   typedef struct {
      logic        iv;
      logic [11:0] pc;
      logic [31:0] ins;
      logic        rdy;
      logic        fl;
      logic        e_v;
      logic [11:0] e_pc;
      logic [31:0] e_ins;
      logic        e_rdy;
   } vec_t;

   ent_t        q[$];
   logic [11:0] m_pc;
   int          m_stall, m_flush;
   vec_t        tbl[14];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic setv(input int i, input logic iv, input logic [11:0] pc,
                       input logic rdy, input logic fl, input logic ev,
                       input logic [11:0] epc, input logic erdy);
      tbl[i] = '{iv, pc, {20'h0, pc}, rdy, fl, ev, epc,
                 ev ? {20'h0, epc} : NOP, erdy};
   endtask

   task automatic model_reset();
      q.delete();
      m_pc = '0;
      m_stall = 0;
      m_flush = 0;
   endtask

   // Reference: an in-order FIFO of capacity 2, head visible to decode.
   task automatic model_step();
      int n;
      ent_t e;
      n = q.size();
      if (flush) begin
         if (n > 0) m_flush++;
         q.delete();
      end else begin
         if (n > 0 && !id_ready) m_stall++;
         if (n > 0 && id_ready) void'(q.pop_front());
         if (if_valid && n < 2) begin
            e.pc = if_pc;
            e.ins = if_instruction;
            q.push_back(e);
         end
      end
      if (q.size() > 0) m_pc = q[0].pc;
   endtask

   task automatic model_check();
      chk("rnd_valid", id_valid, q.size() > 0);
      chk("rnd_pc", id_pc, m_pc);
      chk("rnd_instr", id_instruction, q.size() > 0 ? q[0].ins : NOP);
      chk("rnd_if_ready", if_ready, q.size() < 2);
`ifdef IFID_PERF_CNT_EN
      chk("rnd_stall", stall_cycles, m_stall > 65535 ? 65535 : m_stall);
      chk("rnd_flush", flush_count, m_flush > 65535 ? 65535 : m_flush);
      chk("rnd_stall_sat", s_stall, m_stall > 3 ? 3 : m_stall);
      chk("rnd_flush_sat", s_flush, m_flush > 3 ? 3 : m_flush);
`endif
   endtask

   task automatic idle();
      if_valid = 1'b0;
      if_pc = '0;
      if_instruction = '0;
      id_ready = 1'b0;
      flush = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [11:0] pc,
                        input logic rdy, input logic fl);
      if_valid = iv;
      if_pc = pc;
      if_instruction = {20'h0, pc};
      id_ready = rdy;
      flush = fl;
   endtask

   initial begin
      w_iv = 1'b0; w_ipc = '0; w_iins = '0; w_idr = 1'b0;
      idle();
      rst = 1'b1;
      #2;
      chk("async_rst_valid", id_valid, 1'b0);
      do_reset();

      chk("rst_valid", id_valid, 1'b0);
      chk("rst_pc", id_pc, 12'h0);
      chk("rst_instr", id_instruction, NOP);
      chk("rst_if_ready", if_ready, 1'b1);
      chk("wide_rst_instr", w_oins, 16'h0013);
      chk("wide_rst_pc", w_opc, 32'h0);

      w_iv = 1'b1; w_ipc = 32'hDEADBEEF; w_iins = 16'hA5A5; w_idr = 1'b1;
      step();
      w_iv = 1'b0;
      chk("wide_valid", w_idv, 1'b1);
      chk("wide_pc", w_opc, 32'hDEADBEEF);
      chk("wide_instr", w_oins, 16'hA5A5);
      chk("wide_if_ready", w_irdy, 1'b1);
      step();
      chk("wide_idle_instr", w_oins, 16'h0013);

`ifdef IFID_PERF_CNT_EN
      drive(1'b1, 12'h040, 1'b0, 1'b0);
      step();
      drive(1'b0, 12'h0, 1'b0, 1'b0);
      repeat (3) step();
      chk("perf_stall3", stall_cycles, 16'd3);
      chk("perf_stall3_sat", s_stall, 2'd3);
      flush = 1'b1;
      step();
      step();
      flush = 1'b0;
      chk("perf_flush1", flush_count, 16'd1);
      chk("perf_stall_after_flush", stall_cycles, 16'd3);
      drive(1'b1, 12'h044, 1'b0, 1'b0);
      step();
      drive(1'b0, 12'h0, 1'b0, 1'b0);
      repeat (5) step();
      chk("perf_stall8", stall_cycles, 16'd8);
      chk("perf_stall_saturated", s_stall, 2'd3);
`endif

      do_reset();
      setv(0,  1, 12'h000, 1, 0, 1, 12'h000, 1);
      setv(1,  1, 12'h004, 1, 0, 1, 12'h004, 1);
      setv(2,  1, 12'h008, 1, 0, 1, 12'h008, 1);
      setv(3,  1, 12'h00C, 1, 0, 1, 12'h00C, 1);
      setv(4,  0, 12'h000, 1, 0, 0, 12'h00C, 1);
      setv(5,  1, 12'h010, 0, 0, 1, 12'h010, 1);
      setv(6,  1, 12'h014, 0, 0, 1, 12'h010, 0);
      setv(7,  0, 12'h000, 0, 0, 1, 12'h010, 0);
      setv(8,  0, 12'h000, 1, 0, 1, 12'h014, 1);
      setv(9,  0, 12'h000, 1, 0, 0, 12'h014, 1);
      setv(10, 1, 12'h020, 0, 0, 1, 12'h020, 1);
      setv(11, 1, 12'h024, 0, 0, 1, 12'h020, 0);
      setv(12, 1, 12'h028, 0, 1, 0, 12'h020, 1);
      setv(13, 0, 12'h000, 1, 0, 0, 12'h020, 1);
      foreach (tbl[i]) begin
         if_valid = tbl[i].iv;
         if_pc = tbl[i].pc;
         if_instruction = tbl[i].ins;
         id_ready = tbl[i].rdy;
         flush = tbl[i].fl;
         step();
         chk($sformatf("tbl%0d_valid", i), id_valid, tbl[i].e_v);
         chk($sformatf("tbl%0d_pc", i), id_pc, tbl[i].e_pc);
         chk($sformatf("tbl%0d_instr", i), id_instruction, tbl[i].e_ins);
         chk($sformatf("tbl%0d_if_ready", i), if_ready, tbl[i].e_rdy);
      end

      drive(1'b1, 12'h030, 1'b0, 1'b0);
      step();
      drive(1'b1, 12'h034, 1'b0, 1'b0);
      step();
      drive(1'b0, 12'h0, 1'b0, 1'b0);
      chk("full_if_ready", if_ready, 1'b0);
      #3 rst = 1'b1;
      #1;
      chk("midrst_valid", id_valid, 1'b0);
      chk("midrst_instr", id_instruction, NOP);
      chk("midrst_pc", id_pc, 12'h0);
      chk("midrst_if_ready", if_ready, 1'b1);
      #1 rst = 1'b0;
      id_ready = 1'b1;
      step();
      chk("post_rst_valid", id_valid, 1'b0);

      do_reset();
      for (int c = 0; c < 500; c++) begin
         if_valid = $urandom_range(0, 9) < 7;
         if_pc = 12'($urandom);
         if_instruction = $urandom;
         id_ready = $urandom_range(0, 9) < 6;
         flush = $urandom_range(0, 19) == 0;
         model_step();
         step();
         model_check();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/if_id_stage_reg.md
Name: if_id_stage_reg

Overview:
- Parametrised IF/ID pipeline register, successor to the fixed 12-bit PC / 32-bit instruction IF/ID register.
- Adds valid/ready handshake on both sides, a 2-entry skid buffer (full throughput with registered if_ready), synchronous flush with NOP injection, and async reset.
- Sits between fetch (PC + instruction memory) and decode.

Parameters:
- PC_WIDTH, 12, width of the PC field.
- INSTR_WIDTH, 32, width of the instruction field.
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0), truncated/zero-extended to INSTR_WIDTH.
- CNT_WIDTH, 16, perf-counter width; used only with IFID_PERF_CNT_EN.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch presents PC/instruction.
- if_ready  out  1  stage can accept; driven directly from a register (= ~skid_valid).
- if_pc  in  PC_WIDTH  fetch PC.
- if_instruction  in  INSTR_WIDTH  fetched instruction.
- flush  in  1  squash all held entries (branch/jump redirect).
- id_valid  out  1  decode entry valid.
- id_ready  in  1  decode accepts the current entry.
- id_pc  out  PC_WIDTH  decode PC.
- id_instruction  out  INSTR_WIDTH  decode instruction; NOP_INSTR whenever id_valid=0.
- stall_cycles  out  CNT_WIDTH  only with IFID_PERF_CNT_EN.
- flush_count  out  CNT_WIDTH  only with IFID_PERF_CNT_EN.

Behaviour:
- State:
  - Main slot {main_valid, id_pc, id_instruction} drives the outputs; id_valid = main_valid.
  - Skid slot {skid_valid, skid_pc, skid_instr}.
- Reset (async, while rst=1):
  - main_valid=0, skid_valid=0, id_pc=0, id_instruction=NOP_INSTR, skid_pc=0, skid_instr=NOP_INSTR.
  - if_ready=1, counters=0.
- Handshake events:
  - acc = if_valid & if_ready.
  - drn = main_valid & id_ready.
  - Data is held stable while id_valid=1 and id_ready=0.
- Latency: 1 cycle from an accepted input to id_valid; throughput 1 instruction/cycle when id_ready stays high.
- Next state when flush=0, evaluated in order:
  - skid_valid & drn: main <- skid; skid_valid <- 0. acc is impossible because if_ready=0.
  - skid_valid & !drn: hold everything.
  - !skid_valid & acc & (!main_valid | drn): main <- input; main_valid <- 1.
  - !skid_valid & acc & main_valid & !drn: skid <- input; skid_valid <- 1, so if_ready=0 next cycle.
  - !skid_valid & !acc & drn: main_valid <- 0; id_instruction <- NOP_INSTR; id_pc holds.
  - Otherwise hold.
- Flush (synchronous, highest priority after reset):
  - main_valid <- 0, skid_valid <- 0, id_instruction <- NOP_INSTR, skid_instr <- NOP_INSTR; id_pc holds.
  - An input accepted in the flush cycle is discarded (if_ready may be 1; fetch treats it as consumed).
  - id_ready in the flush cycle is ignored.
- Boundaries:
  - Full (both slots valid): if_ready=0 until a drain.
  - Empty with id_ready=1: no effect.
  - Reset asserted mid-stream: all entries lost immediately (async), outputs to reset values.
  - Reset deassertion takes effect at the next clock edge.
- Width rule: no arithmetic on PC/instruction; fields pass through bit-exact.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- Defined:
  - stall_cycles increments each cycle with id_valid=1 & id_ready=0 & flush=0.
  - flush_count increments each flush cycle in which main_valid|skid_valid=1.
  - Both counters saturate at all-ones, clear only on rst, and are exposed as ports.
- Undefined: counters and their ports do not exist; core behaviour is identical.

Test Plan:
- Reset then stream, id_ready=1: inputs PC 0x0/0x4/0x8/0xC with instructions 0x0/0x4/0x8/0xC on consecutive cycles -> id_valid rises 1 cycle after the first input; id_pc/id_instruction follow 0x0..0xC, one per cycle; if_ready stays 1.
- Backpressure: id_ready=0 while sending PC 0x10 then 0x14 -> 0x10 held on the outputs, 0x14 in skid, if_ready=0. Release id_ready -> 0x10, then 0x14 on successive cycles with no loss or duplication; if_ready back to 1 after the skid drains.
- Flush with both slots full (PCs 0x20, 0x24) plus if_valid with PC 0x28 in the same cycle -> next cycle id_valid=0, id_instruction=0x00000013, if_ready=1; 0x28 never appears at decode.
- Async reset mid-stall: assert rst between clock edges with both slots full -> id_valid=0 and id_instruction=0x00000013 immediately, before the next edge.
- Params PC_WIDTH=32, INSTR_WIDTH=16: PC 0xDEADBEEF, instruction 0xA5A5 -> passed bit-exact; idle id_instruction=0x0013.
- With IFID_PERF_CNT_EN: 3 stall cycles and 2 flushes (one while empty) -> stall_cycles=3, flush_count=1. With CNT_WIDTH=2 and 5 stall cycles -> stall_cycles saturates at 3.
